// File: rtl/msb_mask_pipe.sv
// -----------------------------------------------------------------------------
// msb_mask_pipe
//   Pipelined MSB-derived bit transform on a valid/ready stream.
//   The operand's highest set bit is smeared downward over STAGES registered
//   stages (one shift-or per stage). The last stage then applies one of four
//   per-transaction transforms:
//     00 invert every bit above the MSB (MSB and below unchanged)
//     01 smear (MSB and every bit below it set)
//     10 isolate the MSB
//     11 MSB index in the low IW bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of everything in flight
//   in_valid   input transaction valid
//   in_ready   input accepted this cycle when in_valid is also high
//   in_data    N-bit operand
//   in_mode    2-bit transform select
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   N-bit result (0 when out_valid is low)
//   out_zero   operand was all zeros (0 when out_valid is low)
// -----------------------------------------------------------------------------
module msb_mask_pipe #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_zero
);

    localparam int STAGES = $clog2(N);
    localparam int IW     = (STAGES < 1) ? 1 : STAGES;

    // Per-stage state, index 1 is the input side, STAGES feeds the output.
    logic [STAGES:1]            valid_q, valid_d;
    logic [STAGES:1][1:0]       mode_q,  mode_d;
    logic [STAGES:1][N-1:0]     orig_q,  orig_d;
    logic [STAGES:1][N-1:0]     v_q,     v_d;

    logic advance;
    logic accept;

    // -------------------------------------------------------------------------
    // Handshake and next-state
    // -------------------------------------------------------------------------
    always_comb begin
        // The whole pipe moves as one: a stalled output freezes every stage,
        // so bubbles travel with the data instead of being squeezed out.
        advance  = ~valid_q[STAGES] | out_ready;
        in_ready = advance & ~flush;
        accept   = in_valid & in_ready;

        valid_d = valid_q;
        mode_d  = mode_q;
        orig_d  = orig_q;
        v_d     = v_q;

        if (advance) begin
            valid_d[1] = accept;
            mode_d[1]  = in_mode;
            orig_d[1]  = in_data;
            v_d[1]     = in_data | (in_data >> 1);
            // Stage k doubles the smear distance: after stage k every bit
            // within 2^k - 1 positions below the MSB is set.
            for (int k = 2; k <= STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                mode_d[k]  = mode_q[k-1];
                orig_d[k]  = orig_q[k-1];
                v_d[k]     = v_q[k-1] | (v_q[k-1] >> (1 << (k - 1)));
            end
        end

        // Flush only kills the valids; payload registers are don't-care.
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            mode_q  <= '0;
            orig_q  <= '0;
            v_q     <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            orig_q  <= orig_d;
            v_q     <= v_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output transform, combinational from the last stage
    // -------------------------------------------------------------------------
    logic [N-1:0]  v_last;
    logic [N-1:0]  o_last;
    logic [N-1:0]  iso;
    logic [IW-1:0] idx;
    logic [N-1:0]  res;

    always_comb begin
        v_last = v_q[STAGES];
        o_last = orig_q[STAGES];
        // Smeared value is a run of ones ending at the MSB, so the only bit
        // that differs from its upper neighbour is the MSB itself.
        iso    = v_last ^ (v_last >> 1);

        // iso is one-hot (or zero), so OR-ing the set position is an encoder.
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (iso[i]) begin
                idx = idx | IW'(i);
            end
        end

        res = '0;
        unique case (mode_q[STAGES])
            2'b00:   res = ~(o_last ^ v_last);
            2'b01:   res = v_last;
            2'b10:   res = iso;
            default: res = N'(idx);
        endcase

        out_valid = valid_q[STAGES];
        out_data  = out_valid ? res : '0;
        out_zero  = out_valid & (o_last == '0);
    end

endmodule
